// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: destination address codes,
// port count and the default soft-reset timeout.
package router_pkg;

    // Destination address carried in the packet header
    typedef enum logic [1:0] {
        ADDR_P0  = 2'b00,
        ADDR_P1  = 2'b01,
        ADDR_P2  = 2'b10,
        ADDR_INV = 2'b11
    } addr_e;

    localparam int unsigned NUM_PORTS = 3;

    // Consecutive stalled edges before a port's FIFO is soft-reset
    localparam int unsigned SOFT_RESET_TIMEOUT = 30;

endpackage

// File: rtl/router_sync_timeout.sv
// Single-port drain watchdog: counts consecutive edges where the FIFO has
// data but the destination is not reading. When the count reaches TIMEOUT
// it emits a one-cycle soft_reset pulse and starts over.
module router_sync_timeout #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld,
    input  logic read_en,
    output logic soft_reset
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Stall counter with registered pulse on the TIMEOUT-th stalled edge
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (vld && !read_en) begin
            if (cnt == LAST) begin
                cnt        <= '0;
                soft_reset <= 1'b1;
            end else begin
                cnt        <= cnt + 1'b1;
                soft_reset <= 1'b0;
            end
        end else begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_synchronizer.sv
// Router control glue: latches the header destination, steers the FIFO
// write enable and full status, and derives per-port valid flags.
// Per-port drain timeouts are built only when ROUTER_SYNC_SOFT_RESET_EN is
// defined; otherwise soft_reset_0/1/2 are tied low.
module router_synchronizer
    import router_pkg::*;
#(
    parameter int unsigned SOFT_RESET_TIMEOUT = router_pkg::SOFT_RESET_TIMEOUT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       detect_addr,
    input  logic [1:0] data_in,
    input  logic       write_en_reg,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       read_en_0,
    input  logic       read_en_1,
    input  logic       read_en_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    addr_e addr;

    // Capture destination on the header-detect strobe
    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr <= ADDR_P0;
        end else if (detect_addr) begin
            addr <= addr_e'(data_in);
        end
    end

    // One-hot write enable for the latched destination; invalid writes nowhere
    always_comb begin
        write_enb = '0;
        if (write_en_reg) begin
            case (addr)
                ADDR_P0: write_enb = 3'b001;
                ADDR_P1: write_enb = 3'b010;
                ADDR_P2: write_enb = 3'b100;
                default: write_enb = 3'b000;
            endcase
        end
    end

    // Full status of the addressed FIFO; invalid destination never reports full
    always_comb begin
        fifo_full = 1'b0;
        case (addr)
            ADDR_P0: fifo_full = full_0;
            ADDR_P1: fifo_full = full_1;
            ADDR_P2: fifo_full = full_2;
            default: fifo_full = 1'b0;
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

`ifdef ROUTER_SYNC_SOFT_RESET_EN
    router_sync_timeout #(.TIMEOUT(SOFT_RESET_TIMEOUT)) u_timeout_0 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out_0),
        .read_en    (read_en_0),
        .soft_reset (soft_reset_0)
    );

    router_sync_timeout #(.TIMEOUT(SOFT_RESET_TIMEOUT)) u_timeout_1 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out_1),
        .read_en    (read_en_1),
        .soft_reset (soft_reset_1)
    );

    router_sync_timeout #(.TIMEOUT(SOFT_RESET_TIMEOUT)) u_timeout_2 (
        .clock      (clock),
        .resetn     (resetn),
        .vld        (vld_out_2),
        .read_en    (read_en_2),
        .soft_reset (soft_reset_2)
    );
`else
    // Read strobes only feed the watchdogs, which are not built here
    logic unused_read_en;
    assign unused_read_en = ^{read_en_0, read_en_1, read_en_2};

    assign soft_reset_0 = 1'b0;
    assign soft_reset_1 = 1'b0;
    assign soft_reset_2 = 1'b0;
`endif

endmodule

// File: tb/tb_router_synchronizer.sv
// Directed self-checking bench for router_synchronizer. Soft-reset
// expectations follow whether ROUTER_SYNC_SOFT_RESET_EN is defined.
module tb_router_synchronizer;

`ifdef ROUTER_SYNC_SOFT_RESET_EN
    localparam bit SR_EN = 1'b1;
`else
    localparam bit SR_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn;
    logic       detect_addr;
    logic [1:0] data_in;
    logic       write_en_reg;
    logic       full_0, full_1, full_2;
    logic       empty_0, empty_1, empty_2;
    logic       read_en_0, read_en_1, read_en_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int checks = 0;
    int errors = 0;

    router_synchronizer #(.SOFT_RESET_TIMEOUT(30)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .detect_addr  (detect_addr),
        .data_in      (data_in),
        .write_en_reg (write_en_reg),
        .full_0       (full_0),
        .full_1       (full_1),
        .full_2       (full_2),
        .empty_0      (empty_0),
        .empty_1      (empty_1),
        .empty_2      (empty_2),
        .read_en_0    (read_en_0),
        .read_en_1    (read_en_1),
        .read_en_2    (read_en_2),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .vld_out_0    (vld_out_0),
        .vld_out_1    (vld_out_1),
        .vld_out_2    (vld_out_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
            $error("check %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1ns past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0; detect_addr = 1'b0; data_in = 2'b00; write_en_reg = 1'b1;
        full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
        empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
        read_en_0 = 1'b0; read_en_1 = 1'b0; read_en_2 = 1'b0;

        // Reset state
        step(2);
        check("rst_write_enb", write_enb, 3'b001);
        check("rst_soft_reset", {soft_reset_2, soft_reset_1, soft_reset_0}, 3'b000);
        check("rst_vld_out", {vld_out_2, vld_out_1, vld_out_0}, 3'b000);

        // Latch port 2, then write with full=(0,1,1)
        resetn = 1'b1; write_en_reg = 1'b0; detect_addr = 1'b1; data_in = 2'b10;
        step(1);
        detect_addr = 1'b0; write_en_reg = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
        #1;
        check("p2_write_enb", write_enb, 3'b100);
        check("p2_fifo_full", {2'b00, fifo_full}, 3'b001);

        // Same-cycle detect uses the previously latched address
        detect_addr = 1'b1; data_in = 2'b00; full_0 = 1'b1;
        #1;
        check("same_cycle_write_enb", write_enb, 3'b100);
        step(1);
        detect_addr = 1'b0;
        check("p0_write_enb", write_enb, 3'b001);
        check("p0_fifo_full", {2'b00, fifo_full}, 3'b001);

        detect_addr = 1'b1; data_in = 2'b01;
        step(1);
        detect_addr = 1'b0;
        check("p1_write_enb", write_enb, 3'b010);
        check("p1_fifo_full_hi", {2'b00, fifo_full}, 3'b001);
        full_1 = 1'b0;
        #1;
        check("p1_fifo_full_lo", {2'b00, fifo_full}, 3'b000);
        full_1 = 1'b1;

        detect_addr = 1'b1; data_in = 2'b11;
        step(1);
        detect_addr = 1'b0;
        check("inv_write_enb", write_enb, 3'b000);
        check("inv_fifo_full", {2'b00, fifo_full}, 3'b000);
        write_en_reg = 1'b0;
        #1;
        check("we_low_write_enb", write_enb, 3'b000);

        // Valid flags; ports 1 and 2 start being read so no count begins
        empty_0 = 1'b1; empty_1 = 1'b0; empty_2 = 1'b0;
        read_en_1 = 1'b1; read_en_2 = 1'b1;
        #1;
        check("vld_out", {vld_out_2, vld_out_1, vld_out_0}, 3'b110);

        // Port 2 stalls; pulse after edges 30 and 60, port 1 keeps reading
        read_en_2 = 1'b0;
        for (int k = 1; k <= 61; k++) begin
            step(1);
            check($sformatf("p2_timeout_e%0d", k), {2'b00, soft_reset_2},
                  {2'b00, SR_EN && (k == 30 || k == 60)});
            check($sformatf("p1_reading_e%0d", k), {2'b00, soft_reset_1}, 3'b000);
        end
        empty_1 = 1'b1; empty_2 = 1'b1; read_en_1 = 1'b0; read_en_2 = 1'b0;

        // Port 0: 29 stalled edges, one read, 29 stalled, then the 30th
        empty_0 = 1'b0; read_en_0 = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            step(1);
            check($sformatf("p0_stall_a%0d", k), {2'b00, soft_reset_0}, 3'b000);
        end
        read_en_0 = 1'b1;
        step(1);
        check("p0_read_edge", {2'b00, soft_reset_0}, 3'b000);
        read_en_0 = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            step(1);
            check($sformatf("p0_stall_b%0d", k), {2'b00, soft_reset_0}, 3'b000);
        end
        step(1);
        check("p0_stall_b30", {2'b00, soft_reset_0}, {2'b00, SR_EN});

        // Clear port 0, move addr away from 00, then reset at stall edge 20
        empty_0 = 1'b1; detect_addr = 1'b1; data_in = 2'b10;
        step(1);
        detect_addr = 1'b0; empty_0 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check($sformatf("p0_prerst_e%0d", k), {2'b00, soft_reset_0}, 3'b000);
        end
        resetn = 1'b0;
        step(1);
        write_en_reg = 1'b1;
        #1;
        check("midrst_write_enb", write_enb, 3'b001);
        check("midrst_soft_reset", {soft_reset_2, soft_reset_1, soft_reset_0}, 3'b000);
        resetn = 1'b1; write_en_reg = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            step(1);
            check($sformatf("p0_postrst_e%0d", k), {2'b00, soft_reset_0},
                  {2'b00, SR_EN && (k == 30)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
